// File: rtl/key_step_pkg.sv
// ---------------------------------------------------------------------------
// key_step_pkg
// Shared types and helpers for the key_step_ctrl key conditioner.
//   rpt_state_t      : per-key auto-repeat FSM state
//   cnt_width()      : counter width able to hold 0 .. n-1 with one spare bit
//   rpt_cnt_width()  : repeat counter width covering both delay and period
// ---------------------------------------------------------------------------
package key_step_pkg;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_DELAY  = 2'd1,
        R_PERIOD = 2'd2
    } rpt_state_t;

    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int rpt_cnt_width(input int delay_cycles, input int period_cycles);
        return cnt_width((delay_cycles > period_cycles) ? delay_cycles : period_cycles);
    endfunction

endpackage

// File: rtl/key_channel.sv
// ---------------------------------------------------------------------------
// key_channel
// One pushbutton: two-flop synchroniser, counter debouncer, registered
// press/release strobes and an auto-repeat FSM.
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_key_raw    raw asynchronous key level
//   i_repeat_en  auto-repeat enable (already synchronous)
//   o_level      debounced level, 1 = pressed
//   o_press      one-cycle strobe on an accepted press
//   o_release    one-cycle strobe on an accepted release
//   o_strobe     press strobe OR repeat strobe
// ---------------------------------------------------------------------------
module key_channel
    import key_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_raw,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_strobe
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int RW = rpt_cnt_width(REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    // Normalise so that 1 always means pressed before the first flop.
    logic w_key_norm;
    assign w_key_norm = (ACTIVE_LOW != 0) ? ~i_key_raw : i_key_raw;

    logic r_sync1, r_sync2;
    logic r_level;
    logic [DW-1:0] r_cnt;
    rpt_state_t r_state;
    logic [RW-1:0] r_rc;
    logic r_press, r_release, r_strobe;

    logic w_level_next;
    logic [DW-1:0] w_cnt_next;
    logic w_acc_press, w_acc_release;
    rpt_state_t w_state_next;
    logic [RW-1:0] w_rc_next;
    logic w_rpt_fire;

    // Debouncer: any sample equal to the stable level restarts the count.
    always_comb begin
        w_level_next  = r_level;
        w_cnt_next    = r_cnt;
        w_acc_press   = 1'b0;
        w_acc_release = 1'b0;
        if (r_sync2 == r_level) begin
            w_cnt_next = '0;
        end else if (r_cnt == DEB_LAST) begin
            w_level_next  = r_sync2;
            w_cnt_next    = '0;
            w_acc_press   = r_sync2;
            w_acc_release = ~r_sync2;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // Repeat FSM. Release wins over everything; dropping the enable
    // parks the FSM in R_DELAY so the full delay is served again.
    always_comb begin
        w_state_next = r_state;
        w_rc_next    = r_rc;
        w_rpt_fire   = 1'b0;
        if (w_acc_release) begin
            w_state_next = R_IDLE;
            w_rc_next    = '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (w_acc_press) begin
                        w_state_next = R_DELAY;
                        w_rc_next    = '0;
                    end
                end
                R_DELAY: begin
                    if (!i_repeat_en) begin
                        w_rc_next = '0;
                    end else if (r_rc == DLY_LAST) begin
                        w_rpt_fire   = 1'b1;
                        w_rc_next    = '0;
                        w_state_next = R_PERIOD;
                    end else begin
                        w_rc_next = r_rc + 1'b1;
                    end
                end
                R_PERIOD: begin
                    if (!i_repeat_en) begin
                        w_rc_next    = '0;
                        w_state_next = R_DELAY;
                    end else if (r_rc == PER_LAST) begin
                        w_rpt_fire = 1'b1;
                        w_rc_next  = '0;
                    end else begin
                        w_rc_next = r_rc + 1'b1;
                    end
                end
                default: begin
                    w_state_next = R_IDLE;
                    w_rc_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_cnt     <= '0;
            r_state   <= R_IDLE;
            r_rc      <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_strobe  <= 1'b0;
        end else begin
            r_sync1   <= w_key_norm;
            r_sync2   <= r_sync1;
            r_level   <= w_level_next;
            r_cnt     <= w_cnt_next;
            r_state   <= w_state_next;
            r_rc      <= w_rc_next;
            r_press   <= w_acc_press;
            r_release <= w_acc_release;
            r_strobe  <= w_acc_press | w_rpt_fire;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_strobe  = r_strobe;

endmodule

// File: rtl/key_step_ctrl.sv
// ---------------------------------------------------------------------------
// key_step_ctrl
// NUM_KEYS independent key conditioners (synchronise, debounce, strobe,
// auto-repeat). KeyStrobe of the step key feeds the processor step enable.
// Ports:
//   Clk        system clock
//   Reset      asynchronous active-high reset
//   KeyIn      raw key levels
//   RepeatEn   per-key auto-repeat enable
//   KeyLevel   debounced levels, 1 = pressed
//   KeyPress   one-cycle accepted-press strobes
//   KeyRelease one-cycle accepted-release strobes
//   KeyStrobe  press OR repeat strobes
// ---------------------------------------------------------------------------
module key_step_ctrl
    import key_step_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_KEYS-1:0] KeyIn,
    input  logic [NUM_KEYS-1:0] RepeatEn,
    output logic [NUM_KEYS-1:0] KeyLevel,
    output logic [NUM_KEYS-1:0] KeyPress,
    output logic [NUM_KEYS-1:0] KeyRelease,
    output logic [NUM_KEYS-1:0] KeyStrobe
);

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_channel (
                .i_clk       (Clk),
                .i_rst       (Reset),
                .i_key_raw   (KeyIn[gi]),
                .i_repeat_en (RepeatEn[gi]),
                .o_level     (KeyLevel[gi]),
                .o_press     (KeyPress[gi]),
                .o_release   (KeyRelease[gi]),
                .o_strobe    (KeyStrobe[gi])
            );
        end
    endgenerate

endmodule
